// File: rtl/spike_mux_network.sv
// Spike mux network: snapshots a flat per-neuron spike vector on start and streams {index, data} words, one per clock.
// Optional MUX_NETWORK_SKIP_ZERO_EN: emit only nonzero entries via a next-nonzero priority search.
//
// state | meaning
// IDLE  | waiting for en_network; spike_out holds its last word
// SCAN  | emitting one snapshot entry per clock, networkDone with the last one
module spike_mux_network #(
    parameter int Q_DATA_WIDTH   = 2,
    parameter int Q_SIZE         = 1024,
    parameter int SPIKE_OUT_ADDR = 10,
    parameter int SPIKE_OUT_DATA = 2
) (
    input  logic                                     clk,
    input  logic                                     reset_l,
    input  logic                                     en_network,
    input  logic [Q_DATA_WIDTH*Q_SIZE-1:0]           spike_in,
    output logic                                     networkDone,
    output logic [SPIKE_OUT_ADDR+SPIKE_OUT_DATA-1:0] spike_out
);

    localparam int IDX_W = (Q_SIZE > 1) ? $clog2(Q_SIZE) : 1;
    localparam int OUT_W = SPIKE_OUT_ADDR + SPIKE_OUT_DATA;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Q_SIZE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [Q_DATA_WIDTH*Q_SIZE-1:0] snap_q, snap_d;
    logic [OUT_W-1:0]               out_q, out_d;
    logic                           done_q, done_d;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

`ifdef MUX_NETWORK_SKIP_ZERO_EN
    logic [Q_SIZE-1:0]       nz;
    logic                    found;
    logic                    more;
    logic [IDX_W-1:0]        hit_idx;
    logic [Q_DATA_WIDTH-1:0] hit_data;

    always_comb begin
        nz = '0;
        for (int i = 0; i < Q_SIZE; i++) begin
            nz[i] = |snap_q[i*Q_DATA_WIDTH +: Q_DATA_WIDTH];
        end
    end

    // First nonzero entry at or above idx_q, plus whether any nonzero entry follows it,
    // so the scan ends on the same cycle as the last nonzero word.
    always_comb begin
        found   = 1'b0;
        more    = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < Q_SIZE; i++) begin
            if (nz[i] && (IDX_W'(i) >= idx_q)) begin
                if (!found) begin
                    found   = 1'b1;
                    hit_idx = IDX_W'(i);
                end else begin
                    more = 1'b1;
                end
            end
        end
        hit_data = snap_q[hit_idx*Q_DATA_WIDTH +: Q_DATA_WIDTH];
    end
`else
    logic [Q_DATA_WIDTH-1:0] cur_data;

    always_comb begin
        cur_data = snap_q[idx_q*Q_DATA_WIDTH +: Q_DATA_WIDTH];
    end
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_network) begin
                    snap_d  = spike_in;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
`ifdef MUX_NETWORK_SKIP_ZERO_EN
                if (!found) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    out_d = {SPIKE_OUT_ADDR'(hit_idx), SPIKE_OUT_DATA'(hit_data)};
                    if (!more) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = hit_idx + IDX_W'(1);
                    end
                end
`else
                out_d = {SPIKE_OUT_ADDR'(idx_q), SPIKE_OUT_DATA'(cur_data)};
                if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign spike_out   = out_q;
    assign networkDone = done_q;

endmodule

// File: tb/tb_spike_mux_network.sv
// Directed bench for spike_mux_network (default full-scan build): vector table plus hand sequences.
module tb_spike_mux_network;

    localparam int W  = 2;
    localparam int N  = 1024;
    localparam int AW = 10;
    localparam int OW = AW + W;

    logic              clk = 1'b0;
    logic              reset_l = 1'b0;
    logic              en_network = 1'b0;
    logic [W*N-1:0]    spike_in = '0;
    logic              networkDone;
    logic [OW-1:0]     spike_out;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        int          off;
        logic [11:0] exp_out;
        logic        exp_done;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    spike_mux_network #(
        .Q_DATA_WIDTH  (W),
        .Q_SIZE        (N),
        .SPIKE_OUT_ADDR(AW),
        .SPIKE_OUT_DATA(W)
    ) dut (
        .clk        (clk),
        .reset_l    (reset_l),
        .en_network (en_network),
        .spike_in   (spike_in),
        .networkDone(networkDone),
        .spike_out  (spike_out)
    );

    // Even entries get a, odd entries get b.
    function automatic logic [W*N-1:0] fill(input logic [1:0] a, input logic [1:0] b);
        logic [W*N-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = (i % 2 == 0) ? a : b;
        return r;
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_scan(input logic [W*N-1:0] pat);
        @(negedge clk);
        spike_in   = pat;
        en_network = 1'b1;
        @(posedge clk);
        #1 en_network = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if (networkDone) begin
                seen = 1'b1;
                break;
            end
        end
        check("done_seen", OW'(seen), OW'(1));
    endtask

    initial begin
        int done_cnt;

        vecs[0]  = '{2'b01, 2'b01,    1, 12'h001, 1'b0};
        vecs[1]  = '{2'b01, 2'b01,    2, 12'h005, 1'b0};
        vecs[2]  = '{2'b01, 2'b01,    3, 12'h009, 1'b0};
        vecs[3]  = '{2'b01, 2'b01, 1024, 12'hFFD, 1'b1};
        vecs[4]  = '{2'b10, 2'b11,    1, 12'h002, 1'b0};
        vecs[5]  = '{2'b10, 2'b11,    2, 12'h007, 1'b0};
        vecs[6]  = '{2'b10, 2'b11, 1023, 12'hFFA, 1'b0};
        vecs[7]  = '{2'b00, 2'b11,  512, 12'h7FF, 1'b0};
        vecs[8]  = '{2'b11, 2'b00, 1024, 12'hFFC, 1'b1};
        vecs[9]  = '{2'b00, 2'b00,    1, 12'h000, 1'b0};
        vecs[10] = '{2'b00, 2'b00, 1024, 12'hFFC, 1'b1};
        vecs[11] = '{2'b11, 2'b10,  513, 12'h803, 1'b0};

        // Reset held: start requests must not get through.
        spike_in = fill(2'b11, 2'b11);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            en_network = ~en_network;
            check("rst_out", spike_out, '0);
            check("rst_done", OW'(networkDone), '0);
        end
        @(negedge clk);
        en_network = 1'b0;
        reset_l    = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_out", spike_out, '0);
        check("post_rst_done", OW'(networkDone), '0);

        // Full scan, every cycle checked; busy re-request and snapshot isolation inside it.
        start_scan(fill(2'b01, 2'b01));
        done_cnt = 0;
        for (int n = 1; n <= N; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("full_out", spike_out, {AW'(n - 1), 2'b01});
            check("full_done", OW'(networkDone), OW'(n == N));
            done_cnt += int'(networkDone);
            if (n == 1) spike_in = fill(2'b10, 2'b10);
            if (n == 5) en_network = 1'b1;
            if (n == 6) en_network = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_out", spike_out, 12'hFFD);
            done_cnt += int'(networkDone);
        end
        check("done_once", OW'(done_cnt), OW'(1));

        // Vector table.
        foreach (vecs[v]) begin
            start_scan(fill(vecs[v].a, vecs[v].b));
            repeat (vecs[v].off) @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d_out", v), spike_out, vecs[v].exp_out);
            check($sformatf("vec%0d_done", v), OW'(networkDone), OW'(vecs[v].exp_done));
            if (!networkDone) wait_done();
        end

        // Back-to-back with en_network held high.
        @(negedge clk);
        spike_in   = fill(2'b11, 2'b11);
        en_network = 1'b1;
        wait_done();
        @(negedge clk);
        check("b2b_gap_out", spike_out, 12'hFFF);
        check("b2b_gap_done", OW'(networkDone), '0);
        @(negedge clk);
        check("b2b_e0_out", spike_out, 12'h003);
        check("b2b_e0_done", OW'(networkDone), '0);
        en_network = 1'b0;
        @(negedge clk);
        check("b2b_e1_out", spike_out, 12'h007);
        wait_done();

        // Mid-scan reset at entry 300.
        start_scan(fill(2'b11, 2'b01));
        repeat (301) @(posedge clk);
        @(negedge clk);
        check("mid_e300", spike_out, 12'h4B3);
        reset_l = 1'b0;
        #1;
        check("mid_rst_out", spike_out, '0);
        check("mid_rst_done", OW'(networkDone), '0);
        @(negedge clk);
        reset_l = 1'b1;
        start_scan(fill(2'b11, 2'b01));
        @(posedge clk);
        @(negedge clk);
        check("restart_e0", spike_out, 12'h003);
        @(posedge clk);
        @(negedge clk);
        check("restart_e1", spike_out, 12'h005);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spike_mux_network.md
Name: spike_mux_network

Overview:
- Serialises a wide, flat vector of per-neuron spike codes into a stream of {address, data} words, one neuron per clock.
- On a start pulse it snapshots Q_SIZE entries of Q_DATA_WIDTH bits and scans them in ascending index order.
- Signals completion with a one-cycle done pulse.
- Sits between the neuron-array spike queue and the downstream spike router/encoder.

Parameters:
- Q_DATA_WIDTH, 2, bits per spike entry.
- Q_SIZE, 1024, number of entries in spike_in.
- SPIKE_OUT_ADDR, 10, address field width; must satisfy 2^SPIKE_OUT_ADDR >= Q_SIZE.
- SPIKE_OUT_DATA, 2, data field width; must equal Q_DATA_WIDTH.

Ports:
- clk, input, 1: rising-edge clock.
- reset_l, input, 1: asynchronous active-low reset.
- en_network, input, 1: start request, sampled on the rising edge.
- spike_in, input, Q_DATA_WIDTH*Q_SIZE: entry i occupies bits [i*Q_DATA_WIDTH +: Q_DATA_WIDTH].
- networkDone, output, 1: one-cycle pulse marking the final scanned entry.
- spike_out, output, SPIKE_OUT_ADDR+SPIKE_OUT_DATA: {index[SPIKE_OUT_ADDR-1:0], data[SPIKE_OUT_DATA-1:0]}, address in the MSBs.

Behaviour:
- Reset (reset_l=0, asynchronous):
  - state=IDLE, index=0, snapshot register=0.
  - spike_out=0, networkDone=0.
- States:
  - IDLE: waits for a start.
  - SCAN: emits one entry per cycle.
- IDLE:
  - At an edge where en_network=1, copy spike_in into the internal snapshot, set index=0, go to SCAN.
  - spike_out holds its last value; networkDone=0.
- SCAN, every edge:
  - spike_out <= {index, snapshot[index]}.
  - If index==Q_SIZE-1: networkDone <= 1 and go to IDLE. Otherwise index <= index+1 and networkDone <= 0.
- Latency and duration:
  - Start sampled at edge k → entry 0 appears at edge k+1.
  - Entry Q_SIZE-1 appears at edge k+Q_SIZE, with networkDone high for exactly that one cycle.
  - A scan takes Q_SIZE cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.
- en_network during SCAN is ignored; a scan is never restarted or extended.
- spike_in changes after the capture edge do not affect the current scan.
- en_network high in the same cycle networkDone is high is sampled in IDLE on the next edge and starts a new scan.
- networkDone deasserts the cycle after it is asserted.
- Zero-valued entries are emitted like any other: address advances, data=0.
- Reset mid-scan aborts immediately and returns all state to reset values.
- Index counter width: clog2(Q_SIZE) bits, zero-extended to SPIKE_OUT_ADDR.

Optional Feature:
- Macro: MUX_NETWORK_SKIP_ZERO_EN.
- Defined:
  - In SCAN, entries whose data==0 are skipped; only nonzero entries are emitted, in ascending order, one per cycle, via a next-nonzero priority search.
  - networkDone pulses with the last nonzero entry.
  - If the snapshot is entirely zero, networkDone pulses one cycle after the capture edge and spike_out is unchanged.
  - If the last nonzero entry is emitted before the remaining entries are checked, the scan still ends when no nonzero entries remain.
- Undefined: the full Q_SIZE-cycle scan described in Behaviour.

Test Plan:
- Reset: hold reset_l=0, toggle en_network → spike_out=0, networkDone=0. Release reset with en_network=0 → outputs stay 0.
- Full scan: spike_in={1024{2'b01}}, one-cycle en_network → spike_out=12'h001 at edge+1, 12'h005 at edge+2, 12'h009 at edge+3, …, 12'hFFD at edge+1024 with networkDone=1 only in that cycle. spike_out stays 12'hFFD after.
- Busy ignore: assert en_network again 5 cycles into a scan → scan continues unchanged; networkDone pulses exactly once.
- Snapshot isolation: after capture, change spike_in to all 2'b10 → remaining outputs still carry data 01.
- Back-to-back: hold en_network=1 continuously → new scan starts the edge after networkDone; entry 0 reappears one cycle later.
- Mid-scan reset: pull reset_l low at entry 300 → outputs 0 immediately. After release and a new start, the scan begins at index 0.
